// File: rtl/data_ram_responder_pkg.sv
// rtl/data_ram_responder_pkg.sv - shared defaults and FSM state encodings for data_ram_responder
//
// Purpose: single place for the default geometry/latency values and the
// responder FSM state encodings used by data_ram_responder and data_ram_bank.
// Ports: none (package).
package data_ram_responder_pkg;

  localparam int DEFAULT_ADDR_WORD_BITS = 14;
  localparam int DEFAULT_WAIT_CYCLES    = 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Replace the byte lanes of old_word selected by sel with those of new_word.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  sel);
    logic [31:0] result;
    for (int i = 0; i < 4; i++) begin
      result[8*i +: 8] = sel[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/data_ram_bank.sv
// rtl/data_ram_bank.sv - synchronous 4-lane byte-write word array with write-first read register
//
// Purpose: one write port and one read port on a shared clock. A read of the
// word being written in the same edge returns the post-write value.
// Ports:
//   clk, resetn       clock, async active-low reset (read register only)
//   wr_en/wr_sel      write strobe and byte-lane mask
//   wr_idx/wr_data    write word index and data
//   rd_en/rd_idx      read strobe and word index
//   rd_data           registered read word, held between reads
module data_ram_bank
  import data_ram_responder_pkg::*;
#(
  parameter int ADDR_WORD_BITS = DEFAULT_ADDR_WORD_BITS
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      wr_en,
  input  logic [3:0]                wr_sel,
  input  logic [ADDR_WORD_BITS-1:0] wr_idx,
  input  logic [31:0]               wr_data,
  input  logic                      rd_en,
  input  logic [ADDR_WORD_BITS-1:0] rd_idx,
  output logic [31:0]               rd_data
);

  localparam int DEPTH = 1 << ADDR_WORD_BITS;

  logic [31:0] mem [DEPTH];
  logic [31:0] rd_word;

  // Write-first: forward the lanes being written when both ports hit one word.
  always_comb begin
    rd_word = mem[rd_idx];
    if (wr_en && (wr_idx == rd_idx)) begin
      rd_word = merge_lanes(mem[rd_idx], wr_data, wr_sel);
    end
  end

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_en && wr_sel[i]) begin
        mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_data <= 32'd0;
    end else if (rd_en) begin
      rd_data <= rd_word;
    end
  end

endmodule

// File: rtl/data_ram_responder.sv
// rtl/data_ram_responder.sv - fixed-latency data RAM responder for a pipeline memory stage
//
// Purpose: accepts one read and/or byte-masked write, stalls the pipeline for
// WAIT_CYCLES+1 cycles, then pulses ram_data_valid_o with the read word.
// Ports:
//   clk, resetn                      clock, async active-low reset
//   ram_read_enable_i/addr_i         read request and word-aligned address
//   ram_write_enable_i/select_i      write request and byte-lane mask
//   ram_write_addr_i/data_i          write address and lane-replicated data
//   ram_read_data_o                  registered read word
//   ram_stall_o                      hold while an access is in progress
//   ram_data_valid_o                 one-cycle completion pulse
module data_ram_responder
  import data_ram_responder_pkg::*;
#(
  parameter int ADDR_WORD_BITS = DEFAULT_ADDR_WORD_BITS,
  parameter int WAIT_CYCLES    = DEFAULT_WAIT_CYCLES
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ram_read_enable_i,
  input  logic [31:0] ram_read_addr_i,
  input  logic        ram_write_enable_i,
  input  logic [3:0]  ram_write_select_i,
  input  logic [31:0] ram_write_addr_i,
  input  logic [31:0] ram_write_data_i,
  output logic [31:0] ram_read_data_o,
  output logic        ram_stall_o,
  output logic        ram_data_valid_o
);

  localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);

  logic [1:0]                state;
  logic [2:0]                cnt;
  logic                      lat_re;
  logic                      lat_we;
  logic [3:0]                lat_sel;
  logic [ADDR_WORD_BITS-1:0] lat_ridx;
  logic [ADDR_WORD_BITS-1:0] lat_widx;
  logic [31:0]               lat_wdata;

  logic                      in_we;
  logic                      req;
  logic                      idle;
  logic                      fire;
  logic [ADDR_WORD_BITS-1:0] in_ridx;
  logic [ADDR_WORD_BITS-1:0] in_widx;
  logic                      bank_we;
  logic                      bank_re;
  logic [3:0]                bank_sel;
  logic [ADDR_WORD_BITS-1:0] bank_ridx;
  logic [ADDR_WORD_BITS-1:0] bank_widx;
  logic [31:0]               bank_wdata;
  logic                      unused_addr_bits;

  // Byte offset and bits above the word index are dropped, so addresses alias.
  assign in_ridx = ram_read_addr_i[ADDR_WORD_BITS+1:2];
  assign in_widx = ram_write_addr_i[ADDR_WORD_BITS+1:2];
  assign unused_addr_bits = ^{ram_read_addr_i[31:ADDR_WORD_BITS+2], ram_read_addr_i[1:0],
                              ram_write_addr_i[31:ADDR_WORD_BITS+2], ram_write_addr_i[1:0]};

  assign in_we = ram_write_enable_i & (|ram_write_select_i);
  assign req   = ram_read_enable_i | in_we;
  assign idle  = (state == ST_IDLE);

  // The bank acts on the edge that enters RESP. With zero wait cycles that
  // edge is the request edge itself, so the bank is fed from the live inputs.
  assign fire = idle ? (req && (WAIT_CYCLES == 0)) : ((state == ST_WAIT) && (cnt == 3'd1));

  assign bank_we    = fire & (idle ? in_we : lat_we);
  assign bank_re    = fire & (idle ? ram_read_enable_i : lat_re);
  assign bank_sel   = idle ? ram_write_select_i : lat_sel;
  assign bank_ridx  = idle ? in_ridx : lat_ridx;
  assign bank_widx  = idle ? in_widx : lat_widx;
  assign bank_wdata = idle ? ram_write_data_i : lat_wdata;

  assign ram_stall_o      = resetn & (idle ? req : (state == ST_WAIT));
  assign ram_data_valid_o = (state == ST_RESP);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      cnt       <= 3'd0;
      lat_re    <= 1'b0;
      lat_we    <= 1'b0;
      lat_sel   <= 4'd0;
      lat_ridx  <= '0;
      lat_widx  <= '0;
      lat_wdata <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            lat_re    <= ram_read_enable_i;
            lat_we    <= in_we;
            lat_sel   <= ram_write_select_i;
            lat_ridx  <= in_ridx;
            lat_widx  <= in_widx;
            lat_wdata <= ram_write_data_i;
            cnt       <= WAIT_INIT;
            state     <= (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  data_ram_bank #(
    .ADDR_WORD_BITS(ADDR_WORD_BITS)
  ) u_bank (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (bank_we),
    .wr_sel  (bank_sel),
    .wr_idx  (bank_widx),
    .wr_data (bank_wdata),
    .rd_en   (bank_re),
    .rd_idx  (bank_ridx),
    .rd_data (ram_read_data_o)
  );

endmodule
